// File: rtl/alb_pipe_flags_pkg.sv
// Shared definitions for the registered ALB: opcode encodings, flag bit positions
// and the packed flag record.
package alb_pipe_flags_pkg;

    localparam logic [2:0] ALB_SUB  = 3'b000;
    localparam logic [2:0] ALB_AND  = 3'b001;
    localparam logic [2:0] ALB_OR   = 3'b010;
    localparam logic [2:0] ALB_ADD  = 3'b011;
    localparam logic [2:0] ALB_XOR  = 3'b100;
    localparam logic [2:0] ALB_SHL  = 3'b101;
    localparam logic [2:0] ALB_SHR  = 3'b110;
    localparam logic [2:0] ALB_RSVD = 3'b111;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    // Field order matches the {C,V,N,Z} layout of the persistent flag register.
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alb_flags_t;

endpackage

// File: rtl/alb_pipe_flags_core.sv
// Combinational ALB datapath: add/sub with carry-in, logic ops, shifts, and the
// C/V/N/Z flags of the result.
module alb_pipe_flags_core
    import alb_pipe_flags_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic [WIDTH-1:0] MR,
    input  logic [WIDTH-1:0] MS,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z
);

    logic [SHAMT_W-1:0] sh;
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     sum_sub;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;

    assign sh      = MS[SHAMT_W-1:0];
    assign sum_add = {1'b0, MR} + {1'b0, MS} + {{WIDTH{1'b0}}, cin};
    assign sum_sub = {1'b0, MR} + {1'b0, ~MS} + {{WIDTH{1'b0}}, cin};
    // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_w   = {1'b0, MR} << sh;
    assign shr_w   = {MR, 1'b0} >> sh;

    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALB_SUB: begin
                r = sum_sub[WIDTH-1:0];
                c = sum_sub[WIDTH];
                v = (MR[WIDTH-1] != MS[WIDTH-1]) & (sum_sub[WIDTH-1] != MR[WIDTH-1]);
            end
            ALB_AND: r = MR & MS;
            ALB_OR:  r = MR | MS;
            ALB_ADD: begin
                r = sum_add[WIDTH-1:0];
                c = sum_add[WIDTH];
                v = (MR[WIDTH-1] == MS[WIDTH-1]) & (sum_add[WIDTH-1] != MR[WIDTH-1]);
            end
            ALB_XOR: r = MR ^ MS;
            ALB_SHL: begin
                r = shl_w[WIDTH-1:0];
                c = shl_w[WIDTH];
            end
            ALB_SHR: begin
                r = shr_w[WIDTH:1];
                c = shr_w[0];
            end
            ALB_RSVD: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

    assign n = r[WIDTH-1];
    assign z = ~|r;

endmodule

// File: rtl/alb_pipe_flags.sv
// Registered ALB with valid/ready handshake, one output stage and a persistent
// {C,V,N,Z} flag register whose C can feed the next op's carry-in.
module alb_pipe_flags
    import alb_pipe_flags_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] MR,
    input  logic [WIDTH-1:0] MS,
    input  logic             CI,
    input  logic             use_cf,
    input  logic [2:0]       ALB_MI,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F_ALB,
    output logic             CO,
    output logic             VO,
    output logic             NO,
    output logic             ZO,
    output logic [3:0]       flags_q
);

    logic             cin;
    logic             accept;
    logic [WIDTH-1:0] res_r;
    alb_flags_t       res_flags;
    logic [3:0]       flags_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] f_q;
    alb_flags_t       res_q;

    // flags_q updates at accept, so a chained op sees the previous carry even
    // while that previous result is still stalled in the output stage.
    assign cin = use_cf ? flags_q[FLAG_C] : CI;

    alb_pipe_flags_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .MR  (MR),
        .MS  (MS),
        .cin (cin),
        .op  (ALB_MI),
        .r   (res_r),
        .c   (res_flags.c),
        .v   (res_flags.v),
        .n   (res_flags.n),
        .z   (res_flags.z)
    );

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        flags_d         = 4'b0000;
        flags_d[FLAG_C] = res_flags.c;
        flags_d[FLAG_V] = res_flags.v;
        flags_d[FLAG_N] = res_flags.n;
        flags_d[FLAG_Z] = res_flags.z;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            res_q       <= '{c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b1};
            flags_q     <= 4'b0001;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            f_q         <= res_r;
            res_q       <= res_flags;
            flags_q     <= flags_d;
        end else if (out_ready) begin
            // Drain: result and flags keep their last value.
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign F_ALB     = f_q;
    assign CO        = res_q.c;
    assign VO        = res_q.v;
    assign NO        = res_q.n;
    assign ZO        = res_q.z;

endmodule

// File: tb/tb_alb_pipe_flags.sv
// Self-checking bench for alb_pipe_flags: directed vectors with literal expectations
// plus a cycle-level reference model compared on every negative edge.
module tb_alb_pipe_flags;

    localparam logic [2:0] OP_SUB = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] MR;
    logic [7:0] MS;
    logic       CI;
    logic       use_cf;
    logic [2:0] ALB_MI;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] F_ALB;
    logic       CO;
    logic       VO;
    logic       NO;
    logic       ZO;
    logic [3:0] flags_q;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    alb_pipe_flags #(
        .WIDTH   (8),
        .SHAMT_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .MR        (MR),
        .MS        (MS),
        .CI        (CI),
        .use_cf    (use_cf),
        .ALB_MI    (ALB_MI),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F_ALB     (F_ALB),
        .CO        (CO),
        .VO        (VO),
        .NO        (NO),
        .ZO        (ZO),
        .flags_q   (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic in plain integers; returns {C,V,N,Z,result[7:0]}.
    function automatic logic [11:0] ref_op(input logic [2:0] op, input int a, input int b,
                                           input int cin);
        int r, c, v, sa, sb, s, sv, sh;
        logic [11:0] res;
        r  = 0;
        c  = 0;
        v  = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        case (op)
            3'd0: begin
                s  = a + (255 - b) + cin;
                r  = s % 256;
                c  = s / 256;
                sv = sa - sb - 1 + cin;
                v  = (sv < -128 || sv > 127) ? 1 : 0;
            end
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: begin
                s  = a + b + cin;
                r  = s % 256;
                c  = s / 256;
                sv = sa + sb + cin;
                v  = (sv < -128 || sv > 127) ? 1 : 0;
            end
            3'd4: r = a ^ b;
            3'd5: begin
                r = (a << sh) % 256;
                c = (sh == 0) ? 0 : (a >> (8 - sh)) & 1;
            end
            3'd6: begin
                r = a >> sh;
                c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1;
            end
            default: r = 0;
        endcase
        res[11]  = c[0];
        res[10]  = v[0];
        res[9]   = (r >= 128);
        res[8]   = (r == 0);
        res[7:0] = r[7:0];
        return res;
    endfunction

    // Model state: one output slot, displayed result/flags, persistent flags.
    logic       m_full;
    logic [7:0] m_f;
    logic [3:0] m_fl;
    logic [3:0] m_fq;
    logic       m_acc;
    logic [11:0] model_next;

    assign model_next = ref_op(ALB_MI, int'(MR), int'(MS), int'(use_cf ? m_fq[3] : CI));

    always @(posedge clk) begin
        if (!rst_n) begin
            m_full <= 1'b0;
            m_f    <= 8'h00;
            m_fl   <= 4'b0001;
            m_fq   <= 4'b0001;
            m_acc  <= 1'b0;
        end else if (in_valid && (!m_full || out_ready)) begin
            m_full <= 1'b1;
            m_f    <= model_next[7:0];
            m_fl   <= model_next[11:8];
            m_fq   <= model_next[11:8];
            m_acc  <= 1'b1;
        end else begin
            m_acc <= 1'b0;
            if (out_ready) m_full <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            check("in_ready", {31'd0, in_ready}, {31'd0, (!m_full || out_ready)});
            check("F_ALB", {24'd0, F_ALB}, {24'd0, m_f});
            check("flags_out", {28'd0, CO, VO, NO, ZO}, {28'd0, m_fl});
            check("flags_q", {28'd0, flags_q}, {28'd0, m_fq});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic ucf);
        ALB_MI   = o;
        MR       = a;
        MS       = b;
        CI       = ci;
        use_cf   = ucf;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int n_acc;
        int cycles;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ALB_MI    = OP_ADD;
        MR        = 8'h55;
        MS        = 8'h33;
        CI        = 1'b1;
        use_cf    = 1'b0;

        // Reset held two cycles with in_valid asserted.
        tick();
        started = 1'b1;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_F_ALB", {24'd0, F_ALB}, 32'h00);
        check("rst_flags_q", {28'd0, flags_q}, 32'h1);
        check("rst_ZO", {31'd0, ZO}, 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        do_op(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        check("add_ovf_F", {24'd0, F_ALB}, 32'h80);
        check("add_ovf_CVNZ", {28'd0, CO, VO, NO, ZO}, 32'b0110);
        check("add_ovf_valid", {31'd0, out_valid}, 32'd1);

        do_op(OP_SUB, 8'h00, 8'h01, 1'b1, 1'b0);
        check("sub_borrow_F", {24'd0, F_ALB}, 32'hFF);
        check("sub_borrow_CVNZ", {28'd0, CO, VO, NO, ZO}, 32'b0010);

        // 16-bit chain: low word then high word with stored carry.
        do_op(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
        check("chain_lo_F", {24'd0, F_ALB}, 32'h00);
        check("chain_lo_C", {31'd0, CO}, 32'd1);
        do_op(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
        check("chain_hi_F", {24'd0, F_ALB}, 32'h01);
        check("chain_hi_C", {31'd0, CO}, 32'd0);

        do_op(OP_SHL, 8'h81, 8'h01, 1'b0, 1'b0);
        check("shl1_F", {24'd0, F_ALB}, 32'h02);
        check("shl1_C", {31'd0, CO}, 32'd1);
        do_op(OP_SHR, 8'h81, 8'h03, 1'b0, 1'b0);
        check("shr3_F", {24'd0, F_ALB}, 32'h10);
        check("shr3_C", {31'd0, CO}, 32'd0);
        do_op(OP_SHL, 8'h81, 8'h00, 1'b0, 1'b0);
        check("shl0_F", {24'd0, F_ALB}, 32'h81);
        check("shl0_C", {31'd0, CO}, 32'd0);
        do_op(OP_RSV, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("rsvd_F", {24'd0, F_ALB}, 32'h00);
        check("rsvd_CVNZ", {28'd0, CO, VO, NO, ZO}, 32'b0001);

        // Drain, then backpressure for three cycles.
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_hold_F", {24'd0, F_ALB}, 32'h00);
        out_ready = 1'b0;
        do_op(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0);
        check("bp_first_F", {24'd0, F_ALB}, 32'h46);
        ALB_MI   = OP_SUB;
        MR       = 8'h50;
        MS       = 8'h10;
        CI       = 1'b1;
        use_cf   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_F", {24'd0, F_ALB}, 32'h46);
            check("bp_hold_fq", {28'd0, flags_q}, 32'b0000);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_release_F", {24'd0, F_ALB}, 32'h40);
        check("bp_release_C", {31'd0, CO}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check("bp_drain_F", {24'd0, F_ALB}, 32'h40);

        // Random traffic with random stalls; source holds data until accepted.
        n_acc  = 0;
        cycles = 0;
        while (n_acc < 1000 && cycles < 20000) begin
            if (in_valid && m_acc) n_acc++;
            if (!in_valid || m_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ALB_MI   = 3'($urandom_range(0, 7));
                MR       = 8'($urandom_range(0, 255));
                MS       = 8'($urandom_range(0, 255));
                CI       = 1'($urandom_range(0, 1));
                use_cf   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            cycles++;
        end
        check("random_ops_done", {31'd0, (n_acc >= 1000)}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // Reset during a stall.
        out_ready = 1'b0;
        do_op(OP_XOR, 8'h0F, 8'hF0, 1'b0, 1'b0);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_fq", {28'd0, flags_q}, 32'b0010);
        rst_n = 1'b0;
        tick();
        check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        check("rst_stall_fq", {28'd0, flags_q}, 32'h1);
        check("rst_stall_F", {24'd0, F_ALB}, 32'h00);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
